// File: rtl/fnc_timer_pkg.sv
// Shared constants and helpers for the fnc_timer_mc machine timer.
// Optional feature macro: FNC_TIMER_SNAPSHOT_EN (tear-free mtime hi read).
package fnc_timer_pkg;

    localparam logic [4:0]  ADDR_MTIME_LO = 5'd0;
    localparam logic [4:0]  ADDR_MTIME_HI = 5'd1;
    localparam logic [4:0]  ADDR_CMP_BASE = 5'd2;

    // Reset value of every mtimecmp; truncated to CNT_W where used.
    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Word address of the lo half of compare channel k (hi half is +1).
    function automatic logic [4:0] cmp_lo_addr(input int k);
        return ADDR_CMP_BASE + 5'(k * 2);
    endfunction

endpackage

// File: rtl/fnc_timer_cmp.sv
// One compare channel: mtimecmp register with lo/hi write decode and a
// registered unsigned >= comparator against the post-update mtime.
module fnc_timer_cmp
    import fnc_timer_pkg::*;
#(
    parameter int CNT_W  = 64,
    parameter int CH_IDX = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reg_we,
    input  logic [4:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    input  logic [CNT_W-1:0] mtime_next,
    output logic [CNT_W-1:0] cmp_val,
    output logic             int_out
);

    localparam int         HI_W    = CNT_W - 32;
    localparam logic [4:0] LO_ADDR = cmp_lo_addr(CH_IDX);
    localparam logic [4:0] HI_ADDR = cmp_lo_addr(CH_IDX) + 5'd1;

    logic [CNT_W-1:0] cmp_q;
    logic [CNT_W-1:0] cmp_d;
    logic             int_q;
    logic             int_d;

    // Half-word write decode and the compare against the values the
    // registers will hold after this edge.
    always_comb begin
        cmp_d = cmp_q;
        if (reg_we && (reg_addr == LO_ADDR)) begin
            cmp_d = {cmp_q[CNT_W-1:32], reg_wdata};
        end else if (reg_we && (reg_addr == HI_ADDR)) begin
            cmp_d = {reg_wdata[HI_W-1:0], cmp_q[31:0]};
        end else begin
            cmp_d = cmp_q;
        end
        int_d = (mtime_next >= cmp_d);
    end

    // Compare register and level interrupt flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_q <= CMP_RST[CNT_W-1:0];
            int_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            int_q <= int_d;
        end
    end

    assign cmp_val = cmp_q;
    assign int_out = int_q;

endmodule

// File: rtl/fnc_timer_mc.sv
// Multi-channel machine timer: prescaled free-running mtime, NUM_CH compare
// channels and a 32-bit register read mux.
// Optional feature macro: FNC_TIMER_SNAPSHOT_EN adds reg_re and a snapshot
// of mtime hi taken when mtime lo is read, returned on reads of address 1.
module fnc_timer_mc
    import fnc_timer_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 64,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               reg_we,
`ifdef FNC_TIMER_SNAPSHOT_EN
    input  logic               reg_re,
`endif
    input  logic [4:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic [CNT_W-1:0]   mtime,
    output logic               tick,
    output logic [NUM_CH-1:0]  int_timer
);

    localparam int HI_W = CNT_W - 32;

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic               tick_q;
    logic               tick_d;
    logic [CNT_W-1:0]   mtime_q;
    logic [CNT_W-1:0]   mtime_d;
    logic               inc_s;
    logic [CNT_W-1:0]   cmp_s [NUM_CH];
    logic [NUM_CH-1:0]  int_s;
    logic [31:0]        rdata_s;
    logic [31:0]        hi_rd_s;
`ifdef FNC_TIMER_SNAPSHOT_EN
    logic [HI_W-1:0]    snap_q;
    logic [HI_W-1:0]    snap_d;
`endif

    // Prescaler: a tick fires only on an exact match, so lowering prescale
    // below the running count lets it wrap through zero first.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        inc_s  = 1'b0;
        if (enable) begin
            if (cnt_q == prescale) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                inc_s  = 1'b1;
            end else begin
                cnt_d  = cnt_q + PRESC_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // mtime next value: a register write to either half wins over the
    // increment and holds the other half unchanged.
    always_comb begin
        mtime_d = mtime_q;
        if (reg_we && (reg_addr == ADDR_MTIME_LO)) begin
            mtime_d = {mtime_q[CNT_W-1:32], reg_wdata};
        end else if (reg_we && (reg_addr == ADDR_MTIME_HI)) begin
            mtime_d = {reg_wdata[HI_W-1:0], mtime_q[31:0]};
        end else if (inc_s) begin
            mtime_d = mtime_q + CNT_W'(1);
        end else begin
            mtime_d = mtime_q;
        end
    end

    // Counter, tick and mtime registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            mtime_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            mtime_q <= mtime_d;
        end
    end

`ifdef FNC_TIMER_SNAPSHOT_EN
    // Capture mtime hi whenever software reads mtime lo.
    always_comb begin
        if (reg_re && (reg_addr == ADDR_MTIME_LO)) begin
            snap_d = mtime_q[CNT_W-1:32];
        end else begin
            snap_d = snap_q;
        end
    end

    // Snapshot register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign hi_rd_s = 32'(snap_q);
`else
    assign hi_rd_s = 32'(mtime_q[CNT_W-1:32]);
`endif

    // Compare channels; each sees the post-update mtime.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        fnc_timer_cmp #(
            .CNT_W  (CNT_W),
            .CH_IDX (k)
        ) u_cmp (
            .clk        (clk),
            .rst_n      (rst_n),
            .reg_we     (reg_we),
            .reg_addr   (reg_addr),
            .reg_wdata  (reg_wdata),
            .mtime_next (mtime_d),
            .cmp_val    (cmp_s[k]),
            .int_out    (int_s[k])
        );
    end

    // Read mux; unimplemented addresses fall through to zero.
    always_comb begin
        rdata_s = 32'd0;
        case (reg_addr)
            ADDR_MTIME_LO: rdata_s = mtime_q[31:0];
            ADDR_MTIME_HI: rdata_s = hi_rd_s;
            default: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    rdata_s = rdata_s
                        | ((reg_addr == cmp_lo_addr(k)) ? cmp_s[k][31:0] : 32'd0)
                        | ((reg_addr == (cmp_lo_addr(k) + 5'd1))
                           ? 32'(cmp_s[k][CNT_W-1:32]) : 32'd0);
                end
            end
        endcase
    end

    assign reg_rdata = rdata_s;
    assign mtime     = mtime_q;
    assign tick      = tick_q;
    assign int_timer = int_s;

endmodule

// File: tb/tb_fnc_timer_mc.sv
// Self-checking bench for fnc_timer_mc (default parameters).
module tb_fnc_timer_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  prescale = 8'd0;
    logic        reg_we = 1'b0;
    logic [4:0]  reg_addr = 5'd0;
    logic [31:0] reg_wdata = 32'd0;
    logic [31:0] reg_rdata;
    logic [63:0] mtime;
    logic        tick;
    logic [1:0]  int_timer;
`ifdef FNC_TIMER_SNAPSHOT_EN
    logic        reg_re = 1'b0;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    fnc_timer_mc #(.NUM_CH(2), .CNT_W(64), .PRESC_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .prescale  (prescale),
        .reg_we    (reg_we),
`ifdef FNC_TIMER_SNAPSHOT_EN
        .reg_re    (reg_re),
`endif
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .mtime     (mtime),
        .tick      (tick),
        .int_timer (int_timer)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_int;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        step();
        reg_we    = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
`ifdef FNC_TIMER_SNAPSHOT_EN
        if (a == 5'd1) begin
            reg_addr = 5'd0;
            reg_re   = 1'b1;
            step();
            reg_re   = 1'b0;
        end else begin
            reg_re   = 1'b0;
        end
`endif
        reg_addr = a;
        #1;
        chk(name, {32'd0, reg_rdata}, {32'd0, exp});
    endtask

    initial begin
        logic no_early;

        // register write / read-back table, counter frozen
        vecs[0] = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  32'h1234_5678, 2'b00};
        vecs[1] = '{1'b1, 5'd1,  32'hDEAD_BEEF, 5'd1,  32'hDEAD_BEEF, 2'b00};
        vecs[2] = '{1'b1, 5'd2,  32'h0000_0014, 5'd2,  32'h0000_0014, 2'b00};
        vecs[3] = '{1'b1, 5'd3,  32'h0000_0000, 5'd3,  32'h0000_0000, 2'b01};
        vecs[4] = '{1'b1, 5'd4,  32'hA5A5_0000, 5'd4,  32'hA5A5_0000, 2'b01};
        vecs[5] = '{1'b1, 5'd5,  32'h0000_0005, 5'd5,  32'h0000_0005, 2'b11};
        vecs[6] = '{1'b0, 5'd0,  32'h0000_0000, 5'd6,  32'h0000_0000, 2'b11};
        vecs[7] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 32'h0000_0000, 2'b11};
        vecs[8] = '{1'b1, 5'd3,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 2'b10};
        vecs[9] = '{1'b1, 5'd1,  32'h0000_0000, 5'd1,  32'h0000_0000, 2'b00};

        // reset state
        enable = 1'b0;
        do_reset();
        chk("rst_mtime", mtime, 64'd0);
        chk("rst_tick", {63'd0, tick}, 64'd0);
        chk("rst_int", {62'd0, int_timer}, 64'd0);
        rd_chk("rst_cmp0_lo", 5'd2, 32'hFFFF_FFFF);
        rd_chk("rst_cmp1_hi", 5'd5, 32'hFFFF_FFFF);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                step();
            end
            chk($sformatf("vec%0d_int", i), {62'd0, int_timer}, {62'd0, vecs[i].exp_int});
            rd_chk($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rdata);
        end
        rd_chk("tbl_mtime_lo", 5'd0, 32'h1234_5678);

        // prescale 0: tick every cycle
        prescale = 8'd0;
        enable   = 1'b1;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("p0_mtime%0d", i), mtime, 64'(i));
            chk($sformatf("p0_tick%0d", i), {63'd0, tick}, 64'd1);
        end
        chk("p0_int", {62'd0, int_timer}, 64'd0);

        // prescale 3: tick every 4th cycle, then freeze
        prescale = 8'd3;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("p3_tick%0d", i), {63'd0, tick}, {63'd0, (i % 4) == 0});
        end
        chk("p3_mtime", mtime, 64'd5);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
        end
        chk("freeze_mtime", mtime, 64'd5);
        chk("freeze_tick", {63'd0, tick}, 64'd0);

        // compare channels at 20 and 25
        prescale = 8'd0;
        do_reset();
        wr(5'd2, 32'd20);
        wr(5'd3, 32'd0);
        wr(5'd4, 32'd25);
        wr(5'd5, 32'd0);
        chk("cmp_pre_int", {62'd0, int_timer}, 64'd0);
        enable = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            chk($sformatf("cmp_int%0d", i), {62'd0, int_timer},
                {62'd0, (i >= 25), (i >= 20)});
        end
        wr(5'd2, 32'd100);
        chk("cmp_raise_int", {62'd0, int_timer}, 64'h2);
        chk("cmp_raise_mtime", mtime, 64'd31);

        // wrap through all-ones
        enable = 1'b0;
        wr(5'd0, 32'hFFFF_FFFF);
        wr(5'd1, 32'hFFFF_FFFF);
        wr(5'd2, 32'd5);
        chk("wrap_pre_int", {62'd0, int_timer}, 64'h3);
        enable = 1'b1;
        step();
        chk("wrap_mtime", mtime, 64'd0);
        chk("wrap_int", {62'd0, int_timer}, 64'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("wrap_int%0d", i), {62'd0, int_timer}, {63'd0, (i >= 5)});
        end

        // writes coincident with ticks load without the increment
        wr(5'd0, 32'h0000_0100);
        chk("wr_lo_tick", mtime, 64'h0000_0000_0000_0100);
        wr(5'd1, 32'h0000_0007);
        chk("wr_hi_tick", mtime, 64'h0000_0007_0000_0100);
        chk("pre_rst_int", {62'd0, int_timer}, 64'h3);

        // reset mid-operation
        rst_n = 1'b0;
        step();
        enable = 1'b0;
        rst_n  = 1'b1;
        chk("mid_rst_int", {62'd0, int_timer}, 64'd0);
        chk("mid_rst_mtime", mtime, 64'd0);
        chk("mid_rst_tick", {63'd0, tick}, 64'd0);
        rd_chk("mid_rst_cmp_lo", 5'd2, 32'hFFFF_FFFF);
        rd_chk("mid_rst_cmp_hi", 5'd3, 32'hFFFF_FFFF);

        // prescale lowered below the running count: no early tick
        prescale = 8'd5;
        enable   = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
        end
        prescale = 8'd1;
        no_early = 1'b1;
        for (int i = 1; i < 255; i++) begin
            step();
            if (tick !== 1'b0 || mtime !== 64'd0) begin
                no_early = 1'b0;
            end else begin
                no_early = no_early;
            end
        end
        chk("no_early_tick", {63'd0, no_early}, 64'd1);
        step();
        chk("late_tick", {63'd0, tick}, 64'd1);
        chk("late_mtime", mtime, 64'd1);

`ifdef FNC_TIMER_SNAPSHOT_EN
        // tear-free read across a carry
        enable = 1'b0;
        prescale = 8'd0;
        do_reset();
        wr(5'd0, 32'hFFFF_FFFF);
        wr(5'd1, 32'h0000_0001);
        reg_addr = 5'd0;
        reg_re   = 1'b1;
        #1;
        chk("snap_lo", {32'd0, reg_rdata}, 64'hFFFF_FFFF);
        step();
        reg_re = 1'b0;
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("snap_carry", mtime, 64'h0000_0002_0000_0000);
        reg_addr = 5'd1;
        #1;
        chk("snap_hi", {32'd0, reg_rdata}, 64'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fnc_timer_mc.md
Name: fnc_timer_mc

Overview:
- Parametrised successor of the machine timer.
- Free-running CNT_W-bit mtime with programmable prescaler, plus NUM_CH independent compare channels (one per hart or software timer).
- Each channel raises a registered level interrupt.
- mtime and every mtimecmp are writable and readable over a simple 32-bit register port, so RV32 software can set and read them as lo/hi halves.

Parameters:
- NUM_CH, 2: number of compare channels / interrupt outputs (1..8).
- CNT_W, 64: mtime and mtimecmp width (33..64; hi half is CNT_W-32 bits, zero-extended on read).
- PRESC_W, 8: prescaler reload width.

Ports:
- clk  in  1  global clock
- rst_n  in  1  global reset, synchronous, active-low
- enable  in  1  count enable; 0 freezes mtime and the prescaler
- prescale  in  PRESC_W  tick period minus 1 (0 = tick every cycle)
- reg_we  in  1  register write strobe
- reg_addr  in  5  word address: 0 = mtime lo, 1 = mtime hi, 2+2k = cmp[k] lo, 3+2k = cmp[k] hi
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data for reg_addr (combinational)
- mtime  out  CNT_W  current counter value
- tick  out  1  one-cycle pulse on each mtime increment
- int_timer  out  NUM_CH  per-channel interrupt, level

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk. Reset values:
  - mtime = 0
  - prescaler count = 0
  - all mtimecmp = all-ones
  - int_timer = 0
  - tick = 0
  - snapshot = 0
- Prescaler: count increments each cycle while enable=1.
  - When count == prescale: count clears to 0, tick=1 for one cycle, mtime increments by 1.
  - If prescale changes below the current count, the count still advances until it wraps at 2^PRESC_W-1 → 0. No early tick.
- mtime wrap: all-ones + 1 → 0 silently. No flag.
- Register writes take effect at the next edge.
  - A write to mtime lo or hi replaces that half. It overrides an increment in the same cycle: the written half is loaded, the other half is held.
  - Writing an unimplemented address is ignored. Reading one returns 0.
- Compare:
  - int_timer[k] is registered: int_timer[k] <= (mtime_next >= mtimecmp_next[k]), evaluated on the post-update values.
  - Interrupt therefore asserts on the same edge mtime reaches cmp. This is unsigned >=, not >.
  - It stays high until mtimecmp[k] is raised above mtime or mtime is written below it.
- Reset mid-operation: all state returns to reset values on the next edge. Pending interrupts drop.
- Simultaneous mtime write and cmp write: both apply. Compare uses both new values.

Optional Feature:
- Macro: FNC_TIMER_SNAPSHOT_EN.
- Defined: a read of mtime lo (address 0) whose read is accepted (reg_re pulse, extra 1-bit input port added only when defined) latches mtime[CNT_W-1:32] into a snapshot register. A subsequent read of address 1 returns the snapshot, giving a tear-free 64-bit read.
- Undefined: no reg_re port, no snapshot register. Address 1 returns live mtime hi.

Decomposition:
- Package fnc_timer_pkg holds:
  - address constants ADDR_MTIME_LO, ADDR_MTIME_HI, ADDR_CMP_BASE
  - helper function cmp_lo_addr(k)
  - reset constant CMP_RST (all-ones)
- One sub-module, fnc_timer_cmp, instantiated NUM_CH times. It contains the mtimecmp register, lo/hi write decode and the registered >= comparator.
- The top level holds the prescaler, mtime and the read mux.

Test Plan:
- Reset with prescale=0, enable=1, 10 cycles → mtime=10, tick high every cycle, int_timer=0 (cmp all-ones).
- prescale=3, enable=1, 20 cycles → mtime=5, tick pulses every 4th cycle; enable=0 for 8 cycles → mtime stays 5.
- cmp[0]=20, cmp[1]=25, prescale=0 → int_timer[0] rises on the edge mtime becomes 20, int_timer[1] on mtime 25; write cmp[0] lo=100 → int_timer[0] drops next edge.
- Write mtime lo=0xFFFF_FFFF, hi=0xFFFF_FFFF → next tick mtime=0; int_timer with cmp=5 deasserts at wrap and reasserts at mtime=5.
- mtime write coincident with tick → written value loaded, no +1; rst_n=0 for one cycle while int_timer[0]=1 → int_timer=0, cmp reads 0xFFFF_FFFF.
- FNC_TIMER_SNAPSHOT_EN: mtime=0x1_FFFF_FFFF, read lo (0xFFFF_FFFF), wait for mtime to carry, read hi → returns 0x1, not 0x2.
